pos_display_scheduler: RTL

//  Time-shares the single position-to-seven-segment decoder across NUM_CH joystick/servo axes.

---
 rtl/pos_display_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pos_display_scheduler.sv
// Time-shares one position-to-seven-segment decoder across NUM_CH channels.
// It captures clamped ADC samples and round-robins the digits, with a blanking gap between slots.
module pos_display_scheduler #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CH_W      = 1,
    parameter int unsigned POS_W     = 10,
    parameter int unsigned MIN_POS   = 228,
    parameter int unsigned MAX_POS   = 830,
    parameter int unsigned CENTER    = 544,
    parameter int unsigned DWELL     = 50000,
    parameter int unsigned GAP       = 500,
    parameter int unsigned STALE_CYC = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_valid,
    input  logic [CH_W-1:0]   smp_ch,
    input  logic [POS_W-1:0]  smp_pos,
    output logic              smp_ready,
    output logic [POS_W-1:0]  dec_pos,
    output logic              blank,
    output logic [NUM_CH-1:0] digit_en,
    output logic [CH_W-1:0]   cur_ch,
    output logic [NUM_CH-1:0] stale
);

    localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W   = $clog2(STALE_CYC + 1);

    localparam logic [POS_W-1:0] MIN_P      = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0] MAX_P      = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] CENTER_P   = POS_W'(CENTER);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [TMR_W-1:0] STALE_LAST = TMR_W'(STALE_CYC - 1);
    localparam logic [TMR_W-1:0] STALE_MAX  = TMR_W'(STALE_CYC);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [POS_W-1:0]  ch_reg [NUM_CH];
    logic [TMR_W-1:0]  tmr    [NUM_CH];
    logic [NUM_CH-1:0] seen;

    logic              accept, good, bypass, enter_show;
    logic [POS_W-1:0]  clamped, snap_pos;
    logic              snap_seen, snap_stale;
    logic [CH_W-1:0]   next_ch, tgt_ch;

    // Snapshot source for the slot being entered; a sample accepted on the
    // entry edge for that same channel is forwarded ahead of its register.
    always_comb begin
        accept  = smp_valid & smp_ready;
        good    = accept && (32'(smp_ch) < NUM_CH);
        clamped = (smp_pos < MIN_P) ? MIN_P : ((smp_pos > MAX_P) ? MAX_P : smp_pos);
        next_ch = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
        tgt_ch  = (state == S_GAP) ? next_ch : '0;
        enter_show = ((state == S_IDLE) && good) || ((state == S_GAP) && (cnt == GAP_LAST));

        snap_pos   = CENTER_P;
        snap_seen  = 1'b0;
        snap_stale = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (tgt_ch == CH_W'(i)) begin
                snap_pos   = ch_reg[i];
                snap_seen  = seen[i];
                snap_stale = stale[i];
            end
        end
        bypass = good && (smp_ch == tgt_ch);
        if (bypass) begin
            snap_pos   = clamped;
            snap_seen  = 1'b1;
            snap_stale = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_ready <= 1'b0;
            seen      <= '0;
            stale     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_reg[i] <= CENTER_P;
                tmr[i]    <= '0;
            end
        end else begin
            smp_ready <= 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (good && (smp_ch == CH_W'(i))) begin
                    ch_reg[i] <= clamped;
                    seen[i]   <= 1'b1;
                    tmr[i]    <= '0;
                    stale[i]  <= 1'b0;
                end else if (seen[i]) begin
                    if (tmr[i] != STALE_MAX) tmr[i] <= tmr[i] + 1'b1;
                    if (tmr[i] == STALE_LAST) stale[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_ch   <= '0;
            dec_pos  <= CENTER_P;
            blank    <= 1'b1;
            digit_en <= '1;
        end else if (enter_show) begin
            state    <= S_SHOW;
            cnt      <= '0;
            cur_ch   <= tgt_ch;
            dec_pos  <= snap_pos;
            blank    <= ~snap_seen | snap_stale;
            digit_en <= ~(NUM_CH'(1) << tgt_ch);
        end else begin
            case (state)
                S_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state    <= S_GAP;
                        cnt      <= '0;
                        digit_en <= '1;
                        blank    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP:   cnt   <= cnt + 1'b1;
                S_IDLE:  cnt   <= '0;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
